// File: rtl/sram_ctrl.sv
// Word/block bridge onto a 16-bit asynchronous SRAM: 64-bit block reads, 32-bit word writes.
// Define SRAM_CTRL_RANGE_CHECK_EN to reject offsets at or above 2^19 with an err pulse.
module sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter int unsigned BASE        = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        read,
  input  logic        write,
  output logic [63:0] rdata,
  output logic        ready,
  output logic        err,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      r_state;
  logic [1:0]  r_beat;
  logic [3:0]  r_wait;
  logic [16:0] r_blk;
  logic [15:0] r_wdata_hi;
  logic [47:0] r_rbuf;
  logic [63:0] r_rdata;
  logic        r_ready;
  logic [17:0] r_addr;
  logic        r_we_n;
  logic        r_oe_n;
  logic        r_ce_n;
  logic        r_dq_oe;
  logic [15:0] r_dq;
`ifdef SRAM_CTRL_RANGE_CHECK_EN
  logic        r_err;
  logic        w_oor;
`endif

  // 32-bit word index within the SRAM window; o[18:2] serves both read and write mapping
  logic [16:0] w_blk;
  logic        w_last;

  assign w_blk  = 17'((address - 32'(BASE)) >> 2);
  assign w_last = (r_wait == LAST_WAIT);
`ifdef SRAM_CTRL_RANGE_CHECK_EN
  assign w_oor  = ((address - 32'(BASE)) >= 32'h0008_0000);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_beat     <= 2'd0;
      r_wait     <= 4'd0;
      r_blk      <= '0;
      r_wdata_hi <= '0;
      r_rbuf     <= '0;
      r_rdata    <= '0;
      r_ready    <= 1'b0;
      r_addr     <= '0;
      r_we_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_ce_n     <= 1'b1;
      r_dq_oe    <= 1'b0;
      r_dq       <= '0;
`ifdef SRAM_CTRL_RANGE_CHECK_EN
      r_err      <= 1'b0;
`endif
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (write || read) begin
            r_blk <= w_blk;
`ifdef SRAM_CTRL_RANGE_CHECK_EN
            if (w_oor) begin
              r_state <= DONE;
              r_ready <= 1'b1;
              r_err   <= 1'b1;
              if (!write) r_rdata <= '0;
            end else
`endif
            if (write) begin
              r_state    <= WR;
              r_ce_n     <= 1'b0;
              r_we_n     <= 1'b0;
              r_addr     <= {w_blk, 1'b0};
              r_dq_oe    <= 1'b1;
              r_dq       <= wdata[15:0];
              r_wdata_hi <= wdata[31:16];
            end else begin
              r_state <= RD;
              r_ce_n  <= 1'b0;
              r_oe_n  <= 1'b0;
              r_addr  <= {w_blk[16:1], 2'b00};
            end
          end
        end

        // Beat data is staged and only published to rdata once the whole block is in
        RD: begin
          if (w_last) begin
            r_wait <= 4'd0;
            r_beat <= 2'(r_beat + 2'd1);
            r_addr <= {r_blk[16:1], 2'(r_beat + 2'd1)};
            case (r_beat)
              2'd0:    r_rbuf[15:0]  <= SRAM_DQ;
              2'd1:    r_rbuf[31:16] <= SRAM_DQ;
              2'd2:    r_rbuf[47:32] <= SRAM_DQ;
              default: begin
                r_rdata <= {SRAM_DQ, r_rbuf};
                r_state <= DONE;
                r_ready <= 1'b1;
                r_ce_n  <= 1'b1;
                r_oe_n  <= 1'b1;
              end
            endcase
          end else begin
            r_wait <= 4'(r_wait + 4'd1);
          end
        end

        // WE_N rises for the final cycle of each beat so data is held past the strobe
        WR: begin
          if (w_last) begin
            r_wait <= 4'd0;
            if (r_beat[0]) begin
              r_state <= DONE;
              r_ready <= 1'b1;
              r_ce_n  <= 1'b1;
              r_we_n  <= 1'b1;
              r_dq_oe <= 1'b0;
            end else begin
              r_beat <= 2'd1;
              r_addr <= {r_blk, 1'b1};
              r_dq   <= r_wdata_hi;
              r_we_n <= 1'b0;
            end
          end else begin
            r_wait <= 4'(r_wait + 4'd1);
            r_we_n <= (4'(r_wait + 4'd1) == LAST_WAIT);
          end
        end

        DONE: begin
          r_state <= IDLE;
          r_beat  <= 2'd0;
`ifdef SRAM_CTRL_RANGE_CHECK_EN
          r_err   <= 1'b0;
`endif
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign rdata     = r_rdata;
  assign ready     = r_ready;
`ifdef SRAM_CTRL_RANGE_CHECK_EN
  assign err       = r_err;
`else
  assign err       = 1'b0;
`endif
  assign SRAM_ADDR = r_addr;
  assign SRAM_WE_N = r_we_n;
  assign SRAM_OE_N = r_oe_n;
  assign SRAM_CE_N = r_ce_n;
  assign SRAM_UB_N = r_ce_n;
  assign SRAM_LB_N = r_ce_n;
  assign SRAM_DQ   = r_dq_oe ? r_dq : 16'hzzzz;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: SRAM array model on the bus plus a transaction-level reference memory.
module tb_sram_ctrl;

  localparam int unsigned W    = 3;
  localparam int unsigned BASE = 1024;
  localparam int unsigned MEMSZ = 262144;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        read;
  logic        write;
  logic [63:0] rdata;
  logic        ready;
  logic        err;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;
  logic [6:0]  strobes;

  logic [15:0] sram_mem [0:MEMSZ-1];
  logic [15:0] ref_mem  [0:MEMSZ-1];

  int          n_cmp;
  int          n_fail;
  logic [63:0] exp_rdata;

  sram_ctrl #(.WAIT_CYCLES(W), .BASE(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .address   (address),
    .wdata     (wdata),
    .read      (read),
    .write     (write),
    .rdata     (rdata),
    .ready     (ready),
    .err       (err),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (sram_we_n),
    .SRAM_OE_N (sram_oe_n),
    .SRAM_CE_N (sram_ce_n),
    .SRAM_UB_N (sram_ub_n),
    .SRAM_LB_N (sram_lb_n)
  );

  always #5 clk = ~clk;

  assign strobes = {sram_ce_n, sram_ub_n, sram_lb_n, sram_oe_n, sram_we_n, ready, err};

  // Asynchronous SRAM: drives on OE, stores while WE is low
  assign sram_dq = (!sram_oe_n && !sram_ce_n) ? sram_mem[sram_addr] : 16'hzzzz;
  always @(posedge clk) if (!sram_ce_n && !sram_we_n) sram_mem[sram_addr] = sram_dq;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit out_of_range(input logic [31:0] a);
`ifdef SRAM_CTRL_RANGE_CHECK_EN
    return (a - BASE) >= 32'h0008_0000;
`else
    return 1'b0;
`endif
  endfunction

  // Starts at a negedge with the DUT idle; ends at the negedge of the following idle cycle
  task automatic txn(input bit do_rd, input bit do_wr, input logic [31:0] a,
                     input logic [31:0] d, input bit hold);
    logic [31:0] o;
    logic [17:0] exp_addr;
    int n, beat, ph;
    o = a - BASE;
    read = do_rd; write = do_wr; address = a; wdata = d;
    if (out_of_range(a)) begin
      @(negedge clk);
      address = $urandom; wdata = $urandom;
      if (!do_wr) exp_rdata = '0;
      check("oor_strobes", 64'(strobes), 64'(7'b1111111));
      check("oor_rdata", rdata, exp_rdata);
    end else begin
      n = do_wr ? 2 * W : 4 * W;
      for (int k = 1; k <= n; k++) begin
        @(negedge clk);
        if (k == 1) begin address = $urandom; wdata = $urandom; end
        beat = (k - 1) / W;
        ph   = (k - 1) % W;
        if (do_wr) begin
          exp_addr = {o[18:2], beat[0]};
          check("wr_strobes", 64'(strobes), 64'({4'b0001, 1'(ph == W - 1), 2'b00}));
          check("wr_addr", 64'(sram_addr), 64'(exp_addr));
          check("wr_dq", 64'(sram_dq), 64'((beat != 0) ? d[31:16] : d[15:0]));
        end else begin
          exp_addr = {o[18:3], beat[1:0]};
          check("rd_strobes", 64'(strobes), 64'(7'b0000100));
          check("rd_addr", 64'(sram_addr), 64'(exp_addr));
        end
      end
      @(negedge clk);
      if (do_wr) begin
        ref_mem[{o[18:2], 1'b0}] = d[15:0];
        ref_mem[{o[18:2], 1'b1}] = d[31:16];
      end else begin
        exp_rdata = {ref_mem[{o[18:3], 2'd3}], ref_mem[{o[18:3], 2'd2}],
                     ref_mem[{o[18:3], 2'd1}], ref_mem[{o[18:3], 2'd0}]};
      end
      check("done_strobes", 64'(strobes), 64'(7'b1111110));
      check("done_rdata", rdata, exp_rdata);
    end
    if (!hold) begin read = 1'b0; write = 1'b0; end
    @(negedge clk);
    check("single_ready", 64'({ready, sram_ce_n}), 64'(2'b01));
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; exp_rdata = '0;
    read = 1'b0; write = 1'b0; address = '0; wdata = '0;
    for (int i = 0; i < MEMSZ; i++) begin
      sram_mem[i] = 16'($urandom);
      ref_mem[i]  = sram_mem[i];
    end

    // Reset state
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_strobes", 64'(strobes), 64'(7'b1111100));
    check("rst_rdata", rdata, 64'd0);
    check("rst_addr", 64'(sram_addr), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed block read at 1032
    for (int i = 0; i < 4; i++) begin
      sram_mem[4 + i] = 16'(16'h1111 * (i + 1));
      ref_mem[4 + i]  = sram_mem[4 + i];
    end
    txn(1'b1, 1'b0, 32'd1032, 32'd0, 1'b0);
    check("read_1032", rdata, 64'h4444_3333_2222_1111);

    // Directed word write at 1028
    txn(1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 1'b0);
    check("wr_mem_lo", 64'(sram_mem[2]), 64'h0000_0000_0000_BEEF);
    check("wr_mem_hi", 64'(sram_mem[3]), 64'h0000_0000_0000_DEAD);

    // Read and write together: write wins, rdata untouched
    txn(1'b1, 1'b1, 32'd1040, 32'h0123_4567, 1'b0);
    check("both_rdata_kept", rdata, 64'h4444_3333_2222_1111);

    // Reset during cycle 5 of a read
    read = 1'b1; address = BASE + 32'd64;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_strobes", 64'(strobes), 64'(7'b1111100));
    check("abort_rdata", rdata, 64'd0);
    exp_rdata = '0;
    read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_no_ready", 64'(strobes), 64'(7'b1111100));
    txn(1'b1, 1'b0, BASE + 32'd64, 32'd0, 1'b0);

    // Offset at 2^19: rejected with err, or truncated to halfword 0
    txn(1'b1, 1'b0, BASE + 32'h0008_0000, 32'd0, 1'b0);

    // Back-to-back reads with the request held through ready
    txn(1'b1, 1'b0, BASE + 32'd200, 32'd0, 1'b1);
    txn(1'b1, 1'b0, BASE + 32'd208, 32'd0, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      int kind;
      logic [31:0] a;
      bit hold;
      kind = $urandom_range(0, 9);
      a = ($urandom_range(0, 7) == 0) ? 32'($urandom) : BASE + 32'($urandom_range(0, 32'h7FFFF));
      hold = ($urandom_range(0, 3) == 0);
      txn(kind <= 4 || kind == 9, kind >= 5, a, 32'($urandom), hold);
      if (!hold) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          check("gap_idle", 64'({ready, sram_ce_n}), 64'(2'b01));
        end
      end
    end
    read = 1'b0; write = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
